// File: rtl/nonce_uart_tx.sv
// Golden-nonce FIFO feeding an 8N1 UART that sends each 32-bit nonce as four
// little-endian bytes. Optional macro NONCE_DEDUP_EN drops repeats of the last accepted nonce.
module nonce_uart_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_DIV   = 217
) (
  input  logic                          hash_clk,
  input  logic                          reset_n,
  input  logic [31:0]                   nonce_in,
  input  logic                          nonce_valid,
  output logic                          txd,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_MAX = CW'(BAUD_DIV - 1);
  localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  state_t          state, state_next;
  logic [31:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [31:0]     shift_reg, shift_next;
  logic [CW-1:0]   baud_cnt, baud_next;
  logic [2:0]      bit_idx, bit_next;
  logic [1:0]      byte_idx, byte_next;
  logic            push, pop, drop, dup;

`ifdef NONCE_DEDUP_EN
  logic [31:0] last_nonce;
  logic        last_valid;

  assign dup = nonce_valid && last_valid && (nonce_in == last_nonce);

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      last_nonce <= '0;
      last_valid <= 1'b0;
    end else if (push) begin
      last_nonce <= nonce_in;
      last_valid <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // Full/empty decisions use the count from before this cycle's pop.
  assign push = nonce_valid && !dup && (fifo_count < DEPTH);
  assign drop = nonce_valid && !dup && (fifo_count == DEPTH);
  assign pop  = (state == LOAD);

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge hash_clk) begin
    if (push) mem[wr_ptr] <= nonce_in;
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      baud_cnt  <= baud_next;
      bit_idx   <= bit_next;
      byte_idx  <= byte_next;
    end
  end

  // Every bit reloads the counter, so byte boundaries accumulate no drift.
  always_comb begin
    state_next = state;
    shift_next = shift_reg;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    byte_next  = byte_idx;
    case (state)
      IDLE: begin
        if (fifo_count != '0) state_next = LOAD;
      end
      LOAD: begin
        shift_next = mem[rd_ptr];
        byte_next  = '0;
        baud_next  = BAUD_MAX;
        state_next = START;
      end
      START: begin
        if (baud_cnt == '0) begin
          baud_next  = BAUD_MAX;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_cnt - 1'b1;
        end
      end
      DATA: begin
        if (baud_cnt == '0) begin
          baud_next  = BAUD_MAX;
          shift_next = {1'b0, shift_reg[31:1]};
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_next   = bit_idx + 1'b1;
        end else begin
          baud_next = baud_cnt - 1'b1;
        end
      end
      STOP: begin
        if (baud_cnt == '0) begin
          baud_next = BAUD_MAX;
          if (byte_idx != 2'd3) begin
            byte_next  = byte_idx + 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_cnt - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    if (state == START)     txd = 1'b0;
    else if (state == DATA) txd = shift_reg[0];
  end

  assign busy = (state != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_nonce_uart_tx.sv
// Randomized self-checking bench for nonce_uart_tx: a timeline model of the
// serial line and FIFO is compared every cycle, plus directed literal checks.
module tb_nonce_uart_tx;

  localparam int B     = 4;
  localparam int D     = 4;
  localparam int FRAME = 40 * B;
`ifdef NONCE_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic        hash_clk    = 1'b0;
  logic        reset_n     = 1'b0;
  logic [31:0] nonce_in    = '0;
  logic        nonce_valid = 1'b0;
  logic        txd, busy, overflow;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  // Model: queue of buffered nonces, and a position on the transmit timeline
  // (0 idle, 1 load, 2..FRAME+1 one cycle of the 40-bit frame each).
  logic [31:0] m_q[$];
  int          m_pos = 0;
  logic [31:0] m_cur = '0;
  bit          m_ovf = 1'b0;
  bit          m_last_valid = 1'b0;
  logic [31:0] m_last = '0;

  logic [31:0] rx_q[$];
  int          rx_start[$];
  logic [39:0] rx_bits;
  bit          rx_abort;
  int          rx_st;

  nonce_uart_tx #(.FIFO_DEPTH(D), .BAUD_DIV(B)) dut (
    .hash_clk   (hash_clk),
    .reset_n    (reset_n),
    .nonce_in   (nonce_in),
    .nonce_valid(nonce_valid),
    .txd        (txd),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 hash_clk = ~hash_clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic report_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: wait bound expired at cycle %0d", name, cycle);
  endtask

  function automatic logic exp_txd(input int pos, input logic [31:0] cur);
    int t, bitn, byt, b;
    if (pos < 2) return 1'b1;
    t    = pos - 2;
    bitn = t / B;
    byt  = bitn / 10;
    b    = bitn % 10;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur[byt * 8 + b - 1];
  endfunction

  task automatic model_step();
    int old_cnt, old_pos;
    bit dupl;
    old_cnt = m_q.size();
    old_pos = m_pos;
    dupl = DEDUP && nonce_valid && m_last_valid && (nonce_in == m_last);
    if (old_pos == 1) m_cur = m_q.pop_front();
    if (nonce_valid && !dupl) begin
      if (old_cnt < D) begin
        m_q.push_back(nonce_in);
        m_last       = nonce_in;
        m_last_valid = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (old_pos == 0)              m_pos = (old_cnt != 0) ? 1 : 0;
    else if (old_pos == FRAME + 1) m_pos = 0;
    else                           m_pos = old_pos + 1;
  endtask

  initial forever begin
    @(posedge hash_clk);
    cycle++;
  end

  initial forever begin
    @(posedge hash_clk or negedge reset_n);
    if (reset_n !== 1'b1) begin
      m_q.delete();
      m_pos        = 0;
      m_ovf        = 1'b0;
      m_last_valid = 1'b0;
      m_last       = '0;
    end else begin
      model_step();
    end
  end

  initial forever begin
    @(negedge hash_clk);
    check_output("txd", txd, exp_txd(m_pos, m_cur));
    check_output("busy", busy, (m_pos != 0) || (m_q.size() != 0));
    check_output("fifo_count", fifo_count, 32'(m_q.size()));
    check_output("overflow", overflow, m_ovf);
  end

  // Line receiver: samples one cycle into each bit cell, drops aborted frames.
  initial forever begin
    @(negedge hash_clk);
    if (reset_n === 1'b1 && txd === 1'b0) begin
      rx_st    = cycle;
      rx_abort = 1'b0;
      rx_bits  = '0;
      for (int idx = 1; idx <= 39 * B + 1; idx++) begin
        @(negedge hash_clk);
        if (reset_n !== 1'b1) begin
          rx_abort = 1'b1;
          break;
        end
        if (idx % B == 1) rx_bits[idx / B] = txd;
      end
      if (!rx_abort) begin
        check_output("framing", {rx_bits[39], rx_bits[30], rx_bits[29], rx_bits[20],
                                 rx_bits[19], rx_bits[10], rx_bits[9], rx_bits[0]}, 8'b10101010);
        rx_q.push_back({rx_bits[38:31], rx_bits[28:21], rx_bits[18:11], rx_bits[8:1]});
        rx_start.push_back(rx_st);
      end
    end
  end

  task automatic apply_stimulus(input logic [31:0] v);
    @(posedge hash_clk); #1;
    nonce_valid = 1'b1;
    nonce_in    = v;
  endtask

  task automatic idle_cycle();
    @(posedge hash_clk); #1;
    nonce_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge hash_clk); #1;
    nonce_valid = 1'b0;
    reset_n     = 1'b0;
    repeat (2) @(posedge hash_clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (busy !== 1'b0 && n < max_cycles) begin
      @(posedge hash_clk); #1;
      n++;
    end
    check_output("wait_idle", busy, 1'b0);
    repeat (2) @(posedge hash_clk);
    #1;
  endtask

  task automatic wait_pos(input int p, input int max_cycles);
    int n = 0;
    while (m_pos != p && n < max_cycles) begin
      @(posedge hash_clk); #1;
      n++;
    end
    if (m_pos != p) report_timeout("wait_pos");
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cnt, peak;
    logic [31:0] prev;
    repeat (3) @(posedge hash_clk);
    #1;
    reset_n = 1'b1;
    check_output("reset_txd", txd, 1'b1);
    check_output("reset_busy", busy, 1'b0);
    check_output("reset_count", fifo_count, 3'd0);
    check_output("reset_overflow", overflow, 1'b0);

    $display("[TB] single nonce");
    rx_q.delete(); rx_start.delete();
    apply_stimulus(32'h0000318F);
    idle_cycle();
    check_output("n_txd", txd, 1'b1);
    check_output("n_busy", busy, 1'b1);
    @(posedge hash_clk); #1;
    check_output("n1_txd", txd, 1'b1);
    @(posedge hash_clk); #1;
    check_output("n2_txd", txd, 1'b0);
    cnt = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      @(posedge hash_clk); #1;
      cnt++;
    end
    check_output("frame_cycles", cnt, 160);
    check_output("rx_count1", rx_q.size(), 1);
    if (rx_q.size() > 0) check_output("rx_nonce1", rx_q[0], 32'h0000318F);

    $display("[TB] overflow and back-to-back");
    rx_q.delete(); rx_start.delete();
    peak = 0;
    for (int i = 1; i <= 6; i++) begin
      apply_stimulus(32'(i));
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    idle_cycle();
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
    check_output("peak_count", peak, 4);
    check_output("ovf_set", overflow, 1'b1);
    check_output("ovf_count", fifo_count, 3'd4);
    wait_idle(2000);
    check_output("rx_count5", rx_q.size(), 5);
    for (int i = 0; i < rx_q.size() && i < 5; i++) check_output("rx_order", rx_q[i], 32'(i + 1));
    if (rx_start.size() >= 5)
      for (int i = 0; i < 4; i++)
        check_output("idle_gap", rx_start[i + 1] - rx_start[i] - FRAME, 2);

    $display("[TB] strobe coincident with load");
    do_reset();
    rx_q.delete(); rx_start.delete();
    apply_stimulus(32'hA0A0A0A0);
    idle_cycle();
    wait_pos(5, 50);
    apply_stimulus(32'hB1B1B1B1);
    apply_stimulus(32'hC2C2C2C2);
    apply_stimulus(32'hD3D3D3D3);
    apply_stimulus(32'hE4E4E4E4);
    idle_cycle();
    check_output("full_count", fifo_count, 3'd4);
    check_output("full_no_ovf", overflow, 1'b0);
    wait_pos(1, 400);
    nonce_valid = 1'b1;
    nonce_in    = 32'hF5F5F5F5;
    idle_cycle();
    check_output("load_drop_ovf", overflow, 1'b1);
    check_output("load_drop_count", fifo_count, 3'd3);
    wait_pos(5, 50);
    wait_pos(1, 400);
    check_output("pre_load_count", fifo_count, 3'd3);
    nonce_valid = 1'b1;
    nonce_in    = 32'h06060606;
    idle_cycle();
    check_output("load_accept_count", fifo_count, 3'd3);
    wait_idle(2000);
    check_output("rx_count6", rx_q.size(), 6);
    if (rx_q.size() == 6) begin
      check_output("rx_b", rx_q[1], 32'hB1B1B1B1);
      check_output("rx_e", rx_q[4], 32'hE4E4E4E4);
      check_output("rx_g", rx_q[5], 32'h06060606);
    end

    $display("[TB] reset mid-frame");
    rx_q.delete(); rx_start.delete();
    for (int i = 1; i <= 6; i++) apply_stimulus(32'(i * 32'h11));
    idle_cycle();
    wait_pos(2 + 11 * B + 2, 200);
    reset_n = 1'b0;
    #1;
    check_output("abort_txd", txd, 1'b1);
    check_output("abort_count", fifo_count, 3'd0);
    check_output("abort_ovf", overflow, 1'b0);
    check_output("abort_busy", busy, 1'b0);
    @(posedge hash_clk); #1;
    reset_n = 1'b1;
    apply_stimulus(32'hCAFEF00D);
    idle_cycle();
    wait_idle(400);
    check_output("rx_after_reset_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check_output("rx_after_reset", rx_q[0], 32'hCAFEF00D);

    $display("[TB] duplicate nonces");
    rx_q.delete(); rx_start.delete();
    apply_stimulus(32'hDEADBEEF);
    apply_stimulus(32'hDEADBEEF);
    apply_stimulus(32'h12345678);
    idle_cycle();
    wait_idle(1000);
    check_output("dup_frames", rx_q.size(), DEDUP ? 2 : 3);
    if (rx_q.size() >= 2) begin
      check_output("dup_first", rx_q[0], 32'hDEADBEEF);
      check_output("dup_last", rx_q[rx_q.size() - 1], 32'h12345678);
    end

    $display("[TB] random traffic");
    prev = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge hash_clk); #1;
      if ($urandom_range(0, 29) == 0) begin
        nonce_valid = 1'b1;
        nonce_in    = ($urandom_range(0, 2) == 0) ? prev : $urandom;
        prev        = nonce_in;
      end else begin
        nonce_valid = 1'b0;
      end
    end
    idle_cycle();
    wait_idle(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
